// File: rtl/shake_pkg.sv
// Shared SHAKE definitions: mode encoding, per-mode rate in 64-bit words, and
// the output-buffer state encoding.
package shake_pkg;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_t;

    localparam int unsigned RATE_WORDS_128 = 21;
    localparam int unsigned RATE_WORDS_256 = 17;
    localparam int unsigned BLK_CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLOCK = 2'd1,
        DRAIN      = 2'd2
    } obuf_state_t;

endpackage

// File: rtl/shake_output_buffer.sv
// Squeeze-side buffer: captures one rate block per controller write and streams
// it out as W-bit words until the requested output length has been delivered.
module shake_output_buffer
    import shake_pkg::*;
#(
    parameter int unsigned W             = 64,
    parameter int unsigned RATE_MAX_BITS = 1344,
    parameter int unsigned LEN_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic                     cfg_mode,
    input  logic [LEN_BITS-1:0]      cfg_out_words,
    input  logic [RATE_MAX_BITS-1:0] block_in,
    input  logic                     block_we,
    output logic                     output_buffer_available,
    output logic                     last_output_block,
    output logic [W-1:0]             dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     overflow_err
);

    obuf_state_t              state_q, state_d;
    logic [LEN_BITS-1:0]      words_rem_q, words_rem_d;
    logic [BLK_CNT_W-1:0]     blk_cnt_q, blk_cnt_d;
    logic [BLK_CNT_W-1:0]     rate_words_q, rate_words_d;
    logic [RATE_MAX_BITS-1:0] shift_q, shift_d;
    logic                     overflow_q, overflow_d;
    logic                     avail_q, avail_d;
    logic                     last_blk_q, last_blk_d;
    logic [W-1:0]             dout_q, dout_d;
    logic                     dout_valid_q, dout_valid_d;
    logic                     dout_last_q, dout_last_d;

    logic [LEN_BITS-1:0]      req_words;
    logic [BLK_CNT_W-1:0]     take;

    // Next-state, counters and shift register; outputs are registered from next state.
    always_comb begin
        state_d      = state_q;
        words_rem_d  = words_rem_q;
        blk_cnt_d    = blk_cnt_q;
        rate_words_d = rate_words_q;
        shift_d      = shift_q;
        overflow_d   = overflow_q;

        req_words = (cfg_out_words == '0) ? LEN_BITS'(1) : cfg_out_words;
        take      = (words_rem_q <= LEN_BITS'(rate_words_q)) ? BLK_CNT_W'(words_rem_q)
                                                               : rate_words_q;

        if (cfg_load) begin
            rate_words_d = (shake_mode_t'(cfg_mode) == SHAKE256) ? BLK_CNT_W'(RATE_WORDS_256)
                                                                 : BLK_CNT_W'(RATE_WORDS_128);
            words_rem_d  = req_words;
            blk_cnt_d    = '0;
            overflow_d   = 1'b0;
            state_d      = WAIT_BLOCK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (block_we) overflow_d = 1'b1;
                end
                WAIT_BLOCK: begin
                    if (block_we) begin
                        shift_d     = block_in;
                        blk_cnt_d   = take;
                        words_rem_d = words_rem_q - LEN_BITS'(take);
                        state_d     = DRAIN;
                    end
                end
                DRAIN: begin
                    if (block_we) overflow_d = 1'b1;
                    if (dout_ready) begin
                        shift_d   = shift_q >> W;
                        blk_cnt_d = blk_cnt_q - BLK_CNT_W'(1);
                        if (blk_cnt_q == BLK_CNT_W'(1)) begin
                            state_d = (words_rem_q != '0) ? WAIT_BLOCK : IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        avail_d      = (state_d == WAIT_BLOCK);
        last_blk_d   = (state_d == WAIT_BLOCK) && (words_rem_d <= LEN_BITS'(rate_words_d));
        dout_valid_d = (state_d == DRAIN);
        dout_d       = (state_d == DRAIN) ? shift_d[W-1:0] : '0;
        dout_last_d  = (state_d == DRAIN) && (blk_cnt_d == BLK_CNT_W'(1)) && (words_rem_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            words_rem_q  <= '0;
            blk_cnt_q    <= '0;
            rate_words_q <= '0;
            shift_q      <= '0;
            overflow_q   <= 1'b0;
            avail_q      <= 1'b0;
            last_blk_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_rem_q  <= words_rem_d;
            blk_cnt_q    <= blk_cnt_d;
            rate_words_q <= rate_words_d;
            shift_q      <= shift_d;
            overflow_q   <= overflow_d;
            avail_q      <= avail_d;
            last_blk_q   <= last_blk_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign output_buffer_available = avail_q;
    assign last_output_block       = last_blk_q;
    assign dout                    = dout_q;
    assign dout_valid              = dout_valid_q;
    assign dout_last               = dout_last_q;
    assign overflow_err            = overflow_q;

endmodule

// File: tb/tb_shake_output_buffer.sv
// Scoreboard bench for shake_output_buffer: stimulus pushes expected words per
// captured block; a negedge monitor pops and compares on every handshake.
module tb_shake_output_buffer;

    localparam int unsigned W    = 64;
    localparam int unsigned RB   = 1344;
    localparam int unsigned LB   = 16;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic          cfg_mode;
    logic [LB-1:0] cfg_out_words;
    logic [RB-1:0] block_in;
    logic          block_we;
    logic          output_buffer_available;
    logic          last_output_block;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          overflow_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rem   = 0;
    int   rate  = 21;
    bit   bp_en = 1'b0;

    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_abort = 1'b1;
    logic [W-1:0]  prev_dout  = '0;

    shake_output_buffer #(.W(W), .RATE_MAX_BITS(RB), .LEN_BITS(LB)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cfg_load                (cfg_load),
        .cfg_mode                (cfg_mode),
        .cfg_out_words           (cfg_out_words),
        .block_in                (block_in),
        .block_we                (block_we),
        .output_buffer_available (output_buffer_available),
        .last_output_block       (last_output_block),
        .dout                    (dout),
        .dout_valid              (dout_valid),
        .dout_ready              (dout_ready),
        .dout_last               (dout_last),
        .overflow_err            (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [63:0] lane(input int id, input int i);
        return {16'(id), 16'(i), 32'hD00D_0000 + 32'(id * 64 + i)};
    endfunction

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        dout_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_cfg(input logic m, input int n);
        cfg_mode      = m;
        cfg_out_words = LB'(n);
        cfg_load      = 1'b1;
        exp_q.delete();
        rem  = (n == 0) ? 1 : n;
        rate = m ? 17 : 21;
        tick();
        cfg_load = 1'b0;
        check("cfg_avail", 64'(output_buffer_available), 64'd1);
        check("cfg_valid_low", 64'(dout_valid), 64'd0);
    endtask

    task automatic wait_avail();
        int k = 0;
        while (!output_buffer_available && k < 500) begin
            tick();
            k++;
        end
        if (!output_buffer_available) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_avail: timeout, available=%0b expected 1", output_buffer_available);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (dout_valid && k < 500) begin
            tick();
            k++;
        end
        if (dout_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_drain: timeout, dout_valid=%0b expected 0", dout_valid);
        end
    endtask

    // Capture one block; optionally drain it and measure its occupancy of DRAIN.
    task automatic write_block(input int id, input bit drain);
        int take;
        int cnt;
        take = (rem < rate) ? rem : rate;
        check("last_output_block", 64'(last_output_block), 64'(rem <= rate));
        for (int i = 0; i < 21; i++) block_in[64*i +: 64] = lane(id, i);
        for (int i = 0; i < take; i++) begin
            exp_t e;
            e.data = lane(id, i);
            e.last = (rem == take) && (i == take - 1);
            exp_q.push_back(e);
        end
        rem -= take;
        block_we = 1'b1;
        tick();
        block_we = 1'b0;
        check("capture_valid", 64'(dout_valid), 64'd1);
        if (drain && !bp_en) begin
            cnt = 0;
            while (dout_valid && cnt < 64) begin
                cnt++;
                tick();
            end
            check("drain_cycles", 64'(cnt), 64'(take));
            check("refill_avail", 64'(output_buffer_available), 64'(rem > 0));
        end else if (drain) begin
            wait_drain();
        end
    endtask

    task automatic serve(input int id0);
        int id = id0;
        while (rem > 0) begin
            wait_avail();
            write_block(id, 1'b1);
            id++;
        end
        wait_drain();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("idle_avail", 64'(output_buffer_available), 64'd0);
        check("idle_lastblk", 64'(last_output_block), 64'd0);
    endtask

    task automatic run_request(input logic m, input int n, input int id0);
        do_cfg(m, n);
        serve(id0);
    endtask

    // Monitor: compare every accepted word; check stability across stalls.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !cfg_load && prev_valid && !prev_ready && !prev_abort) begin
                check("stall_valid", 64'(dout_valid), 64'd1);
                check("stall_dout", dout, prev_dout);
            end
            if (!rst && !cfg_load && dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected none", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e.data);
                    check("dout_last", 64'(dout_last), 64'(e.last));
                end
            end
            prev_valid = dout_valid;
            prev_ready = dout_ready;
            prev_dout  = dout;
            prev_abort = rst | cfg_load;
        end
    end

    initial begin
        rst           = 1'b1;
        cfg_load      = 1'b0;
        cfg_mode      = 1'b0;
        cfg_out_words = '0;
        block_in      = '0;
        block_we      = 1'b0;
        dout_ready    = 1'b1;
        tick();
        tick();
        check("rst_avail", 64'(output_buffer_available), 64'd0);
        check("rst_lastblk", 64'(last_output_block), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_last", 64'(dout_last), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        rst = 1'b0;
        tick();

        // Short SHAKE128 request, then multi-block SHAKE256 and exact-multiple SHAKE128.
        run_request(1'b0, 4, 1);
        run_request(1'b1, 40, 10);
        run_request(1'b0, 42, 20);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_extra_avail", 64'(output_buffer_available), 64'd0);
        end
        run_request(1'b0, 0, 30);

        // Backpressure on a two-block request.
        bp_en = 1'b1;
        run_request(1'b0, 30, 40);
        bp_en = 1'b0;
        tick();

        // Write strobe during DRAIN: ignored for data, sets sticky error.
        do_cfg(1'b0, 30);
        wait_avail();
        write_block(50, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 21; i++) block_in[64*i +: 64] = 64'hBAD0_0000_0000_0000 | 64'(i);
        block_we = 1'b1;
        tick();
        block_we = 1'b0;
        check("ovf_set", 64'(overflow_err), 64'd1);
        wait_drain();
        serve(51);
        check("ovf_sticky", 64'(overflow_err), 64'd1);
        do_cfg(1'b1, 3);
        check("ovf_cleared", 64'(overflow_err), 64'd0);
        serve(52);

        // cfg_load mid-DRAIN aborts and restarts.
        do_cfg(1'b0, 21);
        wait_avail();
        write_block(60, 1'b0);
        tick();
        tick();
        tick();
        do_cfg(1'b1, 5);
        check("abort_lastblk", 64'(last_output_block), 64'd1);
        serve(61);

        // Reset mid-DRAIN with the error flag set.
        do_cfg(1'b0, 21);
        wait_avail();
        write_block(70, 1'b0);
        tick();
        block_we = 1'b1;
        tick();
        block_we = 1'b0;
        check("pre_rst_ovf", 64'(overflow_err), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 64'(dout_valid), 64'd0);
        check("mid_rst_dout", dout, 64'd0);
        check("mid_rst_avail", 64'(output_buffer_available), 64'd0);
        check("mid_rst_ovf", 64'(overflow_err), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_request(1'b0, 4, 71);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shake_output_buffer.md
# shake_output_buffer

- Squeeze-side buffer of the SHAKE core.
- Captures one rate-wide block each time the permutation controller asserts its output-buffer write, then serializes it as 64-bit words on a valid/ready stream.
- Tracks the requested output length, and reports buffer availability and last-block status back to the controller, so the controller knows when to squeeze again and when to stop.

## Interface
Parameters:
- W, 64, output word width in bits.
- RATE_MAX_BITS, 1344, width of block_in (SHAKE128 rate).
- LEN_BITS, 16, width of the output-length counter, in words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_load  in  1  pulse: start a new output request.
- cfg_mode  in  1  0 = SHAKE128 (21 words/block), 1 = SHAKE256 (17 words/block).
- cfg_out_words  in  LEN_BITS  requested output length in words; 0 is treated as 1.
- block_in  in  RATE_MAX_BITS  squeezed state rate lanes; word i = bits [64i+63:64i].
- block_we  in  1  controller's output-buffer write strobe.
- output_buffer_available  out  1  buffer empty and more output owed.
- last_output_block  out  1  next captured block is the final one.
- dout  out  W  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  downstream accepts the word.
- dout_last  out  1  dout is the final word of the request.
- overflow_err  out  1  sticky; set when block_we arrives while not available.

## Operation
State machine states: IDLE, WAIT_BLOCK, DRAIN.

Registers:
- words_rem (LEN_BITS): words owed but not yet captured.
- blk_cnt (5 bits): words left in the current block.
- rate_words: 21 or 17, latched from cfg_mode at cfg_load.
- shift register (RATE_MAX_BITS).

IDLE:
- All outputs 0 except overflow_err, which holds its sticky value.
- cfg_load: latch rate_words, words_rem = max(cfg_out_words, 1); go to WAIT_BLOCK.

WAIT_BLOCK:
- output_buffer_available = 1.
- last_output_block = (words_rem ≤ rate_words).
- block_we: shift register = block_in; blk_cnt = min(words_rem, rate_words); words_rem -= blk_cnt; go to DRAIN.

DRAIN:
- dout_valid = 1; dout = shift register [W-1:0].
- On handshake (dout_valid & dout_ready): shift right by W and decrement blk_cnt.
- When blk_cnt hits 0: go to WAIT_BLOCK if words_rem > 0, else IDLE.
- dout_last = (blk_cnt == 1) & (words_rem == 0).
- Words beyond blk_cnt in a truncated final block are discarded.

Boundary conditions:
- block_we outside WAIT_BLOCK: ignored, overflow_err set. It is cleared only by rst or cfg_load.
- cfg_load in any state: aborts the current request. Pending words are dropped, dout_valid falls next cycle, then the new request is loaded and the block goes to WAIT_BLOCK. cfg_load wins over a simultaneous block_we.
- cfg_out_words exactly a multiple of rate_words: last_output_block is asserted in WAIT_BLOCK before the final full block; no empty trailing block.
- LEN_BITS arithmetic is unsigned; words_rem never underflows, since capture uses min().
- Reset mid-operation: immediately IDLE, all outputs 0 including overflow_err, shift register contents don't-care.

## Timing
- All outputs are registered (derived from state/registers only); no combinational input-to-output path.
- Reset values: every output 0; state IDLE.
- Configuration: cfg_load at cycle t → WAIT_BLOCK and available = 1 at t+1.
- Capture: block_we at cycle t → dout_valid = 1 with word 0 at t+1.
- Throughput: with dout_ready held high, one word per cycle. A block of n words occupies DRAIN for n cycles.
- Refill: available reasserts the cycle after the last word handshake of a block, provided more output is owed.
- Stall: dout and dout_valid are held stable while dout_ready = 0; dout_valid never drops without a handshake (except on cfg_load or rst).
- last_output_block is stable throughout WAIT_BLOCK, so the controller may sample it in any cycle it writes.

## Structure
- Shared package shake_pkg holds:
  - mode enum shake_mode_t {SHAKE128, SHAKE256}.
  - constants RATE_WORDS_128 = 21 and RATE_WORDS_256 = 17.
  - the state enum.
- The controller imports the same package.
- Single module; no sub-module is warranted. The shift register and the counters are inline.

## Test plan
- SHAKE128, cfg_out_words = 4, one block_we with ready high → exactly 4 words (lanes 0–3) on consecutive cycles, dout_last on the 4th; last_output_block = 1 in WAIT_BLOCK; IDLE afterwards.
- SHAKE256, cfg_out_words = 40 → three WAIT_BLOCK phases draining 17, 17, 6 words. last_output_block = 0, 0, 1 in those phases; 40 words total; dout_last only on word 40.
- SHAKE128, cfg_out_words = 42 → two full 21-word blocks; last_output_block = 1 before the second capture; no third available pulse.
- Random dout_ready backpressure (50%) on cfg_out_words = 30 → word sequence identical to the ready-high run; dout stable while stalled.
- block_we pulsed during DRAIN → stream unchanged, overflow_err = 1; a following cfg_load clears it.
- rst asserted mid-DRAIN, and cfg_load mid-DRAIN → all outputs 0 immediately (rst) or next cycle (cfg_load); the new request completes correctly.
